ddr_line_bridge: RTL
====================

# ddr_line_bridge

- Converts the single-shot cache-line request from the cache/memory arbiter into a command-plus-burst transaction on a narrow DDR controller port.
- Upstream side is the `cache2mem`/`mem2cache` request–acknowledge pair (`req`, `addr`, `w_data`, `w_en` → `r_data`, `ack`).
- Downstream side is a valid/ready command channel, a valid/ready write-beat channel and a valid-only read-beat channel.
- Sits between the arbiter and the DDR controller in `DRAM` builds, in place of the direct `cache2dram_o`/`dram2cache_i` connection.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width in bits
- BEAT_W, 32, DDR beat width; BEATS = LINE_W/BEAT_W, power of two, ≥2
- TIMEOUT_CYCLES, 255, watchdog limit (only used when the timeout macro is defined)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  line request; held high until ack_o
- addr_i  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored
- w_en_i  in  1  1 = line write, 0 = line read
- w_data_i  in  LINE_W  write line
- r_data_o  out  LINE_W  assembled read line; valid only while ack_o
- ack_o  out  1  one-cycle completion pulse
- cmd_valid_o / cmd_ready_i  out/in  1  command handshake
- cmd_addr_o  out  ADDR_W  line-aligned address
- cmd_we_o  out  1  command type
- wvalid_o / wready_i  out/in  1  write-beat handshake
- wdata_o  out  BEAT_W  write beat
- rvalid_i  in  1  read beat strobe; no backpressure
- rdata_i  in  BEAT_W  read beat
- err_o  out  1  sticky timeout flag

## Operation
**States:** IDLE, CMD, WBEAT, RBEAT, ACK.

- **IDLE:**
  - On req_i, register addr_i (line-aligned), w_en_i and w_data_i.
  - Clear beat_cnt; go to CMD.
- **CMD:**
  - cmd_valid_o = 1 with the registered address and type; these stay stable until cmd_ready_i.
  - On handshake, go to WBEAT if write, else RBEAT.
- **WBEAT:**
  - wvalid_o = 1; wdata_o = line[beat_cnt*BEAT_W +: BEAT_W].
  - Beat 0 is the least-significant slice.
  - Each wready_i increments beat_cnt.
  - The handshake on beat BEATS-1 goes to ACK.
- **RBEAT:**
  - Each rvalid_i writes rdata_i into slice beat_cnt of the line buffer and increments beat_cnt.
  - Beat BEATS-1 goes to ACK.
- **ACK:**
  - ack_o = 1 for one cycle.
  - r_data_o = line buffer for reads, 0 for writes.
  - Then IDLE.
- **Counters:**
  - beat_cnt is log2(BEATS) bits and wraps to 0 on the last beat.
  - No write response is awaited; a write completes once its last beat is accepted.
- **Ignored inputs:**
  - rvalid_i outside RBEAT is ignored; the controller sends no beat in the command-handshake cycle.
  - req_i deassertion mid-transaction is ignored (covers the arbiter kill states): the burst completes and acks normally.
  - req_i in any state other than IDLE is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, line buffer 0.
- **Command start:** cmd_valid_o rises one cycle after req_i is sampled in IDLE.
- **Read latency:** minimum 2 + BEATS cycles from req_i to ack_o (cmd_ready_i already high, rvalid_i back-to-back).
- **Write latency:** same minimum, 2 + BEATS cycles.
- **Registered outputs:** ack_o and r_data_o are registered.
- **Next request:**
  - The arbiter drops or changes req_i in the cycle after ack_o.
  - The bridge samples IDLE no earlier than that cycle, so there is no double issue.
- **Reset mid-burst:**
  - Everything aborts immediately; no ack_o is issued.
  - The controller is reset alongside the bridge.

## Configuration
**Macro DDR_BRIDGE_TIMEOUT_EN defined:**
- A watchdog counter runs in CMD, WBEAT and RBEAT.
- It resets on entering each of those states and on every handshake or beat.
- On reaching TIMEOUT_CYCLES, go to ACK with r_data_o = 0 and set err_o.
- err_o is sticky until reset.
- Late beats arriving after a timeout are ignored.

**Macro undefined:**
- No counter; the bridge waits indefinitely.
- err_o is tied to 0.

## Test plan
- Read, addr 0x8000_0014, cmd_ready_i=1, rdata beats 0x11,0x22,0x33,0x44 consecutive → cmd_addr_o=0x8000_0010, cmd_we_o=0, ack_o at cycle 6, r_data_o=0x00000044_00000033_00000022_00000011.
- Write, w_data_i=0xDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666, wready_i toggling 1/0 → wdata_o sequence 0x77776666, 0x99998888, 0xBBBBAAAA, 0xDDDDCCCC, each held until accepted; single ack_o, r_data_o=0.
- cmd_ready_i held 0 for 10 cycles → cmd_valid_o, cmd_addr_o, cmd_we_o stable throughout; no beat accepted; completion proceeds after the ready.
- req_i dropped in RBEAT after beat 1 → remaining beats collected; ack_o still pulses; no new cmd_valid_o until a fresh req_i in IDLE.
- DDR_BRIDGE_TIMEOUT_EN, read with only 2 beats delivered → ack_o after TIMEOUT_CYCLES idle cycles, r_data_o=0, err_o=1 and stays 1; the next read completes normally with err_o still 1.
- rst_n asserted mid-write burst → all outputs 0 asynchronously; after release, the bridge is in IDLE and a new read completes correctly.

Source files
------------

// File: rtl/ddr_line_bridge.sv
// Bridges one cache-line request/ack onto a DDR command channel plus a BEAT_W-wide burst.
// Optional watchdog: define DDR_BRIDGE_TIMEOUT_EN to abort stalled bursts and raise sticky err_o.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for req_i; captures address, type, line
//   S_CMD   | presenting command until cmd_ready_i
//   S_WBEAT | streaming write beats, LSB slice first
//   S_RBEAT | collecting read beats into the line buffer
//   S_ACK   | one-cycle ack_o with r_data_o
module ddr_line_bridge #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int BEAT_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              w_en_i,
  input  logic [LINE_W-1:0] w_data_i,
  output logic [LINE_W-1:0] r_data_o,
  output logic              ack_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              cmd_we_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [BEAT_W-1:0] wdata_o,
  input  logic              rvalid_i,
  input  logic [BEAT_W-1:0] rdata_i,
  output logic              err_o
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WBEAT, S_RBEAT, S_ACK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_inc;
  logic              last_beat;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_nxt;

  assign beat_inc  = beat_cnt + CNT_W'(1);
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // Line buffer with the incoming read beat merged, so the final beat reaches r_data_o directly.
  always_comb begin
    line_nxt = line_q;
    line_nxt[beat_cnt*BEAT_W +: BEAT_W] = rdata_i;
  end

`ifdef DDR_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            busy;
  logic            progress;
  logic            timeout;

  assign busy     = (state == S_CMD) || (state == S_WBEAT) || (state == S_RBEAT);
  assign progress = ((state == S_CMD)   && cmd_ready_i) ||
                    ((state == S_WBEAT) && wready_i)    ||
                    ((state == S_RBEAT) && rvalid_i);
  assign timeout  = busy && !progress && (wd_cnt == '0);
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      line_q      <= '0;
      r_data_o    <= '0;
      ack_o       <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_we_o    <= 1'b0;
      wvalid_o    <= 1'b0;
      wdata_o     <= '0;
`ifdef DDR_BRIDGE_TIMEOUT_EN
      wd_cnt      <= WD_LOAD;
      err_o       <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
`ifdef DDR_BRIDGE_TIMEOUT_EN
      wd_cnt <= (busy && !progress) ? wd_cnt - WD_W'(1) : WD_LOAD;
      if (timeout) begin
        cmd_valid_o <= 1'b0;
        wvalid_o    <= 1'b0;
        wdata_o     <= '0;
        r_data_o    <= '0;
        ack_o       <= 1'b1;
        err_o       <= 1'b1;
        beat_cnt    <= '0;
        state       <= S_ACK;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (req_i) begin
            cmd_addr_o  <= addr_i & ALIGN_MASK;
            cmd_we_o    <= w_en_i;
            line_q      <= w_data_i;
            beat_cnt    <= '0;
            cmd_valid_o <= 1'b1;
            state       <= S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            if (cmd_we_o) begin
              wvalid_o <= 1'b1;
              wdata_o  <= line_q[BEAT_W-1:0];
              state    <= S_WBEAT;
            end else begin
              state    <= S_RBEAT;
            end
          end
        end
        S_WBEAT: begin
          if (wready_i) begin
            beat_cnt <= beat_inc;
            if (last_beat) begin
              wvalid_o <= 1'b0;
              wdata_o  <= '0;
              r_data_o <= '0;
              ack_o    <= 1'b1;
              state    <= S_ACK;
            end else begin
              wdata_o  <= line_q[beat_inc*BEAT_W +: BEAT_W];
            end
          end
        end
        S_RBEAT: begin
          if (rvalid_i) begin
            line_q   <= line_nxt;
            beat_cnt <= beat_inc;
            if (last_beat) begin
              r_data_o <= line_nxt;
              ack_o    <= 1'b1;
              state    <= S_ACK;
            end
          end
        end
        S_ACK: begin
          r_data_o <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
